mem_responder: RTL
==================

# mem_responder

Memory-side responder for the CPU's fetch/load path. Accepts word requests addressed by `MAR`, services them from an internal byte-organised memory with two sequential byte accesses, and returns the assembled 16-bit word on `MBR` over a valid/ready response channel. The fetch stage is the initiator on one side of the MAR/MBR interface; this block is the responder on the other side, and it also services word writes.

## Interface
- `MEM_SIZE`, default 256: memory depth in bytes. Addresses `0..MEM_SIZE-1` are valid.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  initiator presents a request.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 selects write, 0 selects read.
- `MAR`  in  16  byte address of the high byte of the word.
- `req_wdata`  in  16  write data; `[15:8]` is stored at MAR, `[7:0]` at MAR+1.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts the response.
- `MBR`  out  16  read data; for writes, an echo of the written word; 0 on error.
- `rsp_err`  out  1  MAR was out of range (MAR ≥ MEM_SIZE).

## Operation
- FSM states: IDLE, ACC_HI, ACC_LO, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch MAR, `req_we`, `req_wdata`, and the range check, then go to ACC_HI.
- ACC_HI:
  - Read: capture `mem[MAR]` into `MBR[15:8]`.
  - Write: store `wdata[15:8]` at `mem[MAR]`.
  - Next state is ACC_LO.
- ACC_LO:
  - Access uses address `(MAR+1) mod MEM_SIZE`, so MAR = MEM_SIZE-1 wraps the low byte to address 0.
  - Read: capture the byte into `MBR[7:0]`.
  - Write: store `wdata[7:0]`.
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1.
  - `MBR` and `rsp_err` are held stable until `rsp_ready`.
  - On the handshake edge, return to IDLE.
- Big-endian byte order throughout.
- Out-of-range request:
  - Walks the same states with the same latency.
  - No memory read or write occurs.
  - `MBR`=16'h0000 and `rsp_err`=1.
- Inputs are sampled only at acceptance. Changes to MAR or `req_wdata` afterwards have no effect.
- Memory contents are not cleared by reset and are undefined until written.

## Timing
- Reset values (asynchronous): state IDLE, `req_ready`=1, `rsp_valid`=0, `MBR`=0, `rsp_err`=0.
- Request accepted at edge E. `rsp_valid` rises after edge E+2, giving 3 cycles to a visible response.
- Response handshake at edge R. `req_ready` is high after R, so the next request is accepted at R+1 at the earliest. Peak throughput is one request per 4 cycles.
- `rsp_ready` may be held high in advance; the response then completes at the first RESP edge.
- `req_valid` is ignored while `req_ready`=0; no request is queued.
- Write-then-read of the same address returns the new data. Writes commit at ACC_HI and ACC_LO, before the write's own response.
- Reset asserted mid-operation:
  - Returns immediately to IDLE and clears outputs.
  - A write interrupted after ACC_HI leaves the high byte committed and the low byte unchanged. This is defined, not an error.
- Memory accesses: synchronous write, combinational read of the byte array.

## Structure
- Package `mem_pkg`: state enum (IDLE/ACC_HI/ACC_LO/RESP), `WORD_W`=16, `BYTE_W`=8, default `MEM_SIZE`=256.
- One sub-module, `byte_ram`:
  - Single-port array of `MEM_SIZE` bytes.
  - Ports: `clk`, `we`, `addr`, `wdata[7:0]`, `rdata[7:0]`.
  - Synchronous write, combinational read, no reset.
- `mem_responder` contains the FSM, address/wdata latches, range check, wrap-increment and MBR assembly.

## Test plan
- Write MAR=0x0010, wdata=0xBEEF; then read MAR=0x0010. Required: write response MBR=0xBEEF with err=0. Read `rsp_valid` rises 3 cycles after accept, MBR=0xBEEF.
- Wrap: write 0x1234 at MAR=0x00FF (MEM_SIZE=256); then read 0x00FF → 0x1234, and byte-read via 0x0000 gives high byte 0x34.
- Out of range: read MAR=0x0100. Required: err=1, MBR=0x0000, same latency. Memory location 0x0000 is unchanged, confirmed by read-back.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in RESP. Required: MBR and `rsp_valid` stable, `req_ready`=0 throughout. After the handshake, `req_ready`=1 next cycle.
- Reset mid-write of 0xAAAA over 0x5555 at MAR=0x20, asserted in ACC_LO. Required: outputs go to their reset values at once; a later read returns 0xAA55.
- Back-to-back: `req_valid` and `rsp_ready` held high with 4 reads. Required: accepts spaced exactly 4 cycles apart, responses in order.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizing for the memory responder: FSM state encoding and word/byte widths.
package mem_pkg;

  localparam int WORD_W           = 16;
  localparam int BYTE_W           = 8;
  localparam int DEFAULT_MEM_SIZE = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_HI = 2'd1,
    ACC_LO = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// MAR/MBR request/response channel between the fetch-side initiator and the memory responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] MAR;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] MBR;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, MAR, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, MBR, rsp_err
  );

  modport slave (
    input  req_valid, req_we, MAR, req_wdata, rsp_ready,
    output req_ready, rsp_valid, MBR, rsp_err
  );

endinterface

// File: rtl/mem_responder_byte_ram.sv
// Single-port byte array: synchronous write, combinational read, contents not reset.
module byte_ram
  import mem_pkg::*;
#(
  parameter  int MEM_SIZE = DEFAULT_MEM_SIZE,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Word responder: accepts a MAR request, performs two big-endian byte accesses, returns MBR.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACC_HI | access byte at MAR (high byte)
// ACC_LO | access byte at (MAR+1) mod MEM_SIZE (low byte)
// RESP   | rsp_valid high, MBR/rsp_err held until rsp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter  int MEM_SIZE = DEFAULT_MEM_SIZE,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam logic [16:0]   ADDR_LIMIT = 17'(MEM_SIZE);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(MEM_SIZE - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] mbr_q, mbr_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  logic              in_range;
  logic [AW-1:0]     addr_lo;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [BYTE_W-1:0] ram_wdata;
  logic [BYTE_W-1:0] ram_rdata;

  assign in_range = ({1'b0, bus.MAR} < ADDR_LIMIT);
  assign addr_lo  = (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);

  // Out-of-range requests still walk ACC_HI/ACC_LO but never touch the array.
  always_comb begin
    ram_addr  = (state_q == ACC_LO) ? addr_lo : addr_q;
    ram_wdata = (state_q == ACC_LO) ? wdata_q[BYTE_W-1:0] : wdata_q[WORD_W-1:BYTE_W];
    ram_we    = we_q && !err_q && ((state_q == ACC_HI) || (state_q == ACC_LO));
  end

  byte_ram #(.MEM_SIZE(MEM_SIZE)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    mbr_d       = mbr_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.MAR[AW-1:0];
          we_d        = bus.req_we;
          wdata_d     = bus.req_wdata;
          err_d       = !in_range;
          req_ready_d = 1'b0;
          state_d     = ACC_HI;
        end
      end
      ACC_HI: begin
        if (err_q) begin
          mbr_d[WORD_W-1:BYTE_W] = '0;
        end else if (we_q) begin
          mbr_d[WORD_W-1:BYTE_W] = wdata_q[WORD_W-1:BYTE_W];
        end else begin
          mbr_d[WORD_W-1:BYTE_W] = ram_rdata;
        end
        state_d = ACC_LO;
      end
      ACC_LO: begin
        if (err_q) begin
          mbr_d[BYTE_W-1:0] = '0;
        end else if (we_q) begin
          mbr_d[BYTE_W-1:0] = wdata_q[BYTE_W-1:0];
        end else begin
          mbr_d[BYTE_W-1:0] = ram_rdata;
        end
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      mbr_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      mbr_q       <= mbr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.MBR       = mbr_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
